// File: rtl/xbus_pkg.sv
// Shared types and constants for the MC3999 XBus arbiter.
package xbus_pkg;

  localparam int XBUS_WIDTH     = 11;
  localparam int XBUS_MAX_PORTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    COOL = 2'd2
  } xbus_state_e;

  // Index width for n ports; a 2-port net still needs one bit.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Round-robin priority picker: first eligible request at or after ptr, with wrap.
module rr_pick
  import xbus_pkg::*;
#(
  parameter int N    = XBUS_MAX_PORTS,
  parameter int IDXW = idx_bits(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic [N-1:0]    excl,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] N_W = (IDXW + 1)'(N);

  logic [N-1:0]  elig;
  logic [IDXW:0] cand;

  assign elig = req & ~excl;

  // Scan from the farthest offset back to ptr so the closest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDXW + 1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (elig[cand[IDXW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus net arbiter: pairs one blocked writer with one blocked reader per transfer.
// Define XBUS_SLX_EN to enable the slx_wake pulse on rising write requests.
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int WIDTH  = XBUS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORTS-1:0]       wr_req,
  input  logic [NPORTS*WIDTH-1:0] wr_dat,
  input  logic [NPORTS-1:0]       rd_req,
  output logic [NPORTS-1:0]       wr_ack,
  output logic [NPORTS-1:0]       rd_ack,
  output logic [WIDTH-1:0]        rd_dat,
  output logic                    slx_wake
);

  localparam int              PW       = idx_bits(NPORTS);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NPORTS - 1);
  localparam logic [NPORTS-1:0] ONE    = NPORTS'(1);

  xbus_state_e       state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_idx_q, wr_idx_d;
  logic [PW-1:0]     rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NPORTS-1:0] wr_ack_q, wr_ack_d;
  logic [NPORTS-1:0] rd_ack_q, rd_ack_d;
  logic [WIDTH-1:0]  rd_dat_q, rd_dat_d;

  logic              wr_found, rd_found;
  logic [PW-1:0]     wr_pick, rd_pick;
  logic [NPORTS-1:0] wr_excl, rd_excl;

  assign wr_excl = '0;
  // A port never reads its own write, so the chosen writer is masked from readers.
  assign rd_excl = ONE << wr_pick;

  rr_pick #(.N(NPORTS), .IDXW(PW)) u_wr_pick (
    .req   (wr_req),
    .ptr   (wr_ptr_q),
    .excl  (wr_excl),
    .valid (wr_found),
    .idx   (wr_pick)
  );

  rr_pick #(.N(NPORTS), .IDXW(PW)) u_rd_pick (
    .req   (rd_req),
    .ptr   (rd_ptr_q),
    .excl  (rd_excl),
    .valid (rd_found),
    .idx   (rd_pick)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    data_d   = data_q;
    wr_ack_d = wr_ack_q;
    rd_ack_d = rd_ack_q;
    rd_dat_d = rd_dat_q;
    case (state_q)
      IDLE: begin
        if (wr_found && rd_found) begin
          wr_idx_d = wr_pick;
          rd_idx_d = rd_pick;
          data_d   = wr_dat[wr_pick*WIDTH +: WIDTH];
          state_d  = XFER;
        end
      end
      XFER: begin
        wr_ack_d = ONE << wr_idx_q;
        rd_ack_d = ONE << rd_idx_q;
        rd_dat_d = data_q;
        wr_ptr_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
        rd_ptr_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
        state_d  = COOL;
      end
      COOL: begin
        wr_ack_d = '0;
        rd_ack_d = '0;
        rd_dat_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      data_q   <= '0;
      wr_ack_q <= '0;
      rd_ack_q <= '0;
      rd_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      data_q   <= data_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;
  assign rd_dat = rd_dat_q;

`ifdef XBUS_SLX_EN
  logic [NPORTS-1:0] wr_req_q, wr_req_d;
  logic              slx_wake_q, slx_wake_d;

  // Rising-edge detect runs in every state so sleepers wake even mid-transfer.
  always_comb begin
    wr_req_d   = wr_req;
    slx_wake_d = |(wr_req & ~wr_req_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q   <= '0;
      slx_wake_q <= 1'b0;
    end else begin
      wr_req_q   <= wr_req_d;
      slx_wake_q <= slx_wake_d;
    end
  end

  assign slx_wake = slx_wake_q;
`else
  assign slx_wake = 1'b0;
`endif

endmodule

// File: doc/xbus_arbiter.md
# xbus_arbiter

Arbiter for one MC3999 XBus net shared by up to `NPORTS` chip ports. Blocking XBus semantics: a write stalls until exactly one reader takes the value, and a read stalls until a writer supplies one. The block pairs one pending writer with one pending reader, moves the 11-bit word, and acknowledges both. It sits between the register-file XBus ports (x0..x3 of each MC3999 instance) and the shared net.

## Interface
- `NPORTS`, 4: number of chip ports on the net (2..8).
- `WIDTH`, 11: data width; matches the register-file word.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  NPORTS  per-port write request; held high until `wr_ack`.
- `wr_dat`  in  NPORTS*WIDTH  per-port write data; port i at bits [i*WIDTH +: WIDTH]; stable while `wr_req[i]` is high.
- `rd_req`  in  NPORTS  per-port read request; held high until `rd_ack`.
- `wr_ack`  out  NPORTS  one-cycle completion pulse to the granted writer.
- `rd_ack`  out  NPORTS  one-cycle completion pulse to the granted reader.
- `rd_dat`  out  WIDTH  transferred word; valid only while some `rd_ack` bit is high, 0 otherwise.
- `slx_wake`  out  1  one-cycle pulse on new write activity (see Configuration).

## Operation
- FSM states: IDLE, XFER, COOL.
- IDLE: at each edge, if any `wr_req` is high and any `rd_req` from a different port is high, latch the writer index, reader index and `wr_dat` of the writer, then go to XFER. Otherwise stay in IDLE.
- Writer selection: round-robin. Port `wr_ptr` has the highest priority, then ascending indices with wrap.
- Reader selection: round-robin from `rd_ptr`, excluding the selected writer's port.
- If the only reader is the writer's own port, no transfer occurs. The block stays in IDLE; this is not an error.
- XFER: on the next edge, register `wr_ack[w]=1`, `rd_ack[r]=1`, `rd_dat`=latched word. Set `wr_ptr=(w+1)%NPORTS` and `rd_ptr=(r+1)%NPORTS`. Go to COOL.
- COOL: on the next edge, clear acks and `rd_dat` to 0. Requests are ignored in this state, which gives requesters one edge to drop `req`. Go to IDLE.
- Exactly one writer and one reader complete per transfer. All other requesters keep waiting.
- Data passes through unmodified; no clamping to ±999 (the register file owns the range rule).
- Reset (asynchronous, any state): state=IDLE, `wr_ptr`=`rd_ptr`=0, all acks 0, `rd_dat`=0, `slx_wake`=0. An in-flight transfer is discarded and neither side is acked.

## Timing
- Requests sampled at edge E0 → acks and `rd_dat` high in the cycle after E1 → low after E2.
- Minimum transfer latency is 2 cycles from sampling to ack. Peak throughput is one transfer per 3 cycles.
- Requesters must deassert `req` at the edge following the ack cycle. A request re-raised after that edge competes normally at the next IDLE sample.
- Requests changing during XFER/COOL have no effect. The latched data word is used.

## Configuration
- `XBUS_SLX_EN` defined: `slx_wake` pulses for one cycle when any `wr_req` bit rises.
  - Detection uses a registered copy of `wr_req`, reset to 0.
  - A rise occurring during XFER/COOL still pulses.
  - This output wakes chips sleeping on `slx`.
- `XBUS_SLX_EN` undefined: `slx_wake` is tied to 0 and the edge-detect register is omitted.

## Structure
- Package `xbus_pkg`:
  - state enum {IDLE, XFER, COOL}
  - `XBUS_WIDTH`=11
  - `XBUS_MAX_PORTS`=8
- Sub-module `rr_pick`: parameterised round-robin priority picker. Inputs: request vector, pointer, exclude mask. Outputs: valid and index. It is instantiated twice, once for writers and once for readers.

## Test plan
- Reset release, no requests → all acks 0, `rd_dat`=0, state stays IDLE for 10 cycles.
- Port 0 writes 42, port 2 reads → `wr_ack[0]` and `rd_ack[2]` pulse together 2 cycles after sampling, with `rd_dat`=42 in that cycle; all low one cycle later.
- Ports 1 and 3 both write (5 and 9), port 0 reads twice → first transfer delivers 5 (port 1), second delivers 9 (port 3); `wr_ptr` advances 0→2→0.
- Port 2 writes 57 and only port 2 reads → no ack for 20 cycles; port 1 then reads → `rd_ack[1]` with `rd_dat`=57.
- Assert `rst_n`=0 during XFER with pending 777 → no acks ever issued for it; after release, pointers are 0 and a fresh request completes normally.
- With `XBUS_SLX_EN`: `wr_req[3]` rises → `slx_wake` high exactly one cycle. Without the macro: `slx_wake` stays 0.
